// File: rtl/chan_select_reg.sv
// chan_select_reg: round-robin channel selector with a one-word output register.
//
// Each cycle the block may take one word from the first requesting channel
// at or after a rotating pointer. The word sits in a registered output slot
// (o_data/o_chan/o_valid) until downstream accepts it.
//
// Handshake: a word transfers downstream on a rising edge where
// o_valid & i_ready; a channel is taken on an edge where its o_grant bit is
// high. o_valid never drops without i_ready, and o_data/o_chan are stable
// while o_valid & ~i_ready.
//
// The two-state FSM (EMPTY/FULL) is exposed directly as o_valid.
//
// Optional feature: define CHAN_SELECT_HOLD_LAST_EN to keep the last
// delivered o_data/o_chan visible while EMPTY instead of returning to
// DEFAULT_VAL / channel 0.

module chan_select_reg #(
  parameter int               WIDTH       = 4,
  parameter int               CHANNELS    = 4,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_en,
  input  logic [CHANNELS-1:0]                               i_valid,
  input  logic [CHANNELS*WIDTH-1:0]                         i_data,
  output logic [CHANNELS-1:0]                               o_grant,
  output logic                                              o_valid,
  output logic [WIDTH-1:0]                                  o_data,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_chan,
  input  logic                                              i_ready
);

  localparam int             PW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [PW:0]    CH_W = (PW+1)'(CHANNELS);
  localparam logic [PW-1:0]  LAST = PW'(CHANNELS - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_data;
  logic [PW-1:0]       r_chan;
  logic [PW-1:0]       r_ptr;

  state_t              w_state_nx;
  logic [WIDTH-1:0]    w_data_nx;
  logic [PW-1:0]       w_chan_nx;
  logic [PW-1:0]       w_ptr_nx;

  logic [PW:0]         w_sum;
  logic                w_found;
  logic [PW-1:0]       w_gidx;
  logic [PW-1:0]       w_ptr_inc;
  logic                w_take;
  logic [CHANNELS-1:0] w_grant;
  logic [WIDTH-1:0]    w_sel;

  // Find the first requesting channel at or after the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(off);
      if (w_sum >= CH_W) w_sum = w_sum - CH_W;
      if (!w_found && i_valid[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_gidx  = w_sum[PW-1:0];
      end
    end
  end

  // A take needs enable, a request, and room in the slot (empty or draining).
  // Reset suppresses it so no grant is shown while i_rst is high.
  assign w_take    = i_en & w_found & ((r_state == ST_EMPTY) | i_ready) & ~i_rst;
  assign w_ptr_inc = (w_gidx == LAST) ? '0 : w_gidx + PW'(1);

  // One-hot grant and the matching data word for the chosen channel.
  always_comb begin
    w_grant = '0;
    w_sel   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (w_gidx == PW'(k)) begin
        w_grant[k] = w_take;
        w_sel      = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and next-register values; holding is the default.
  always_comb begin
    w_state_nx = r_state;
    w_data_nx  = r_data;
    w_chan_nx  = r_chan;
    w_ptr_nx   = r_ptr;
    if (w_take) begin
      w_state_nx = ST_FULL;
      w_data_nx  = w_sel;
      w_chan_nx  = w_gidx;
      w_ptr_nx   = w_ptr_inc;
    end else if ((r_state == ST_FULL) && i_ready) begin
      w_state_nx = ST_EMPTY;
`ifdef CHAN_SELECT_HOLD_LAST_EN
      // Last delivered word and channel stay visible while idle.
`else
      w_data_nx  = DEFAULT_VAL;
      w_chan_nx  = '0;
`endif
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_data  <= DEFAULT_VAL;
      r_chan  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_data  <= w_data_nx;
      r_chan  <= w_chan_nx;
      r_ptr   <= w_ptr_nx;
    end
  end

  assign o_grant = w_grant;
  assign o_valid = (r_state == ST_FULL);
  assign o_data  = r_data;
  assign o_chan  = r_chan;

endmodule

// File: doc/chan_select_reg.md
CHAN_SELECT_REG -- requirements
Module: chan_select_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 4: data bits per channel (>=1).
REQ-002 SHALL have parameter CHANNELS, default 4: number of input channels (>=1).
REQ-003 SHALL have parameter DEFAULT_VAL, default 0 (WIDTH bits): idle value driven on o_data.
REQ-004 SHALL have port i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_en  input  1  grant enable; low blocks new grants.
REQ-007 SHALL have port i_valid  input  CHANNELS  per-channel request, bit k = channel k.
REQ-008 SHALL have port i_data  input  CHANNELS*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port o_grant  output  CHANNELS  one-hot, combinational; channel taken this cycle.
REQ-010 SHALL have port o_valid  output  1  o_data/o_chan hold an unconsumed word.
REQ-011 SHALL have port o_data  output  WIDTH  registered selected word.
REQ-012 SHALL have port o_chan  output  max(1,$clog2(CHANNELS))  index of the source channel.
REQ-013 SHALL have port i_ready  input  1  downstream accepts o_data when o_valid & i_ready.

Function
REQ-014 SHALL implement two states: EMPTY (o_valid=0) and FULL (o_valid=1).
REQ-015 SHALL define take = i_en & |i_valid & (~o_valid | i_ready).
REQ-016 SHALL, on take, grant the first valid channel at or after round-robin pointer ptr, searching upward with wrap CHANNELS-1 -> 0.
REQ-017 SHALL drive o_grant to all zeros whenever take is 0.
REQ-018 SHALL drive o_grant with no combinational dependence on o_data or o_chan.
REQ-019 SHALL, on the edge after a take, load o_data with the granted word, o_chan with the granted index, and set o_valid=1; latency is 1 cycle.
REQ-020 SHALL update ptr to (granted+1) mod CHANNELS on each take, and otherwise hold ptr.
REQ-021 SHALL, in FULL with i_ready=1 and take=1, replace the word in the same edge (back-to-back throughput of 1/cycle).
REQ-022 SHALL, in FULL with i_ready=1 and take=0, go to EMPTY; o_data then follows REQ-033/034.
REQ-023 SHALL, in FULL with i_ready=0, hold o_data, o_chan, o_valid stable and grant nothing.
REQ-024 SHALL, with i_en=0, still let a FULL word drain via i_ready.
REQ-025 SHALL, with CHANNELS=1, keep ptr at 0 and o_chan at 0.
REQ-026 SHALL be latch-free: every combinational output/net assigned on every path.

Reset
REQ-027 SHALL, while i_rst=1, immediately force o_valid=0, o_data=DEFAULT_VAL, o_chan=0, ptr=0, independent of i_clk.
REQ-028 SHALL keep o_grant all zeros while i_rst=1.
REQ-029 SHALL discard an in-flight FULL word on reset mid-operation with no later output.
REQ-030 SHALL permit a grant in the first cycle after i_rst deasserts.

Configuration
REQ-031 SHALL have macro CHAN_SELECT_HOLD_LAST_EN selecting the idle value of o_data/o_chan.
REQ-032 SHALL behave identically under either setting while o_valid=1.
REQ-033 SHALL, without the macro, load o_data=DEFAULT_VAL and o_chan=0 on the FULL->EMPTY edge.
REQ-034 SHALL, with the macro, hold the last delivered o_data and o_chan in EMPTY until the next take or reset.

Verification
REQ-035 SHALL cover round-robin: WIDTH=4, CHANNELS=4, i_valid=4'b1111, i_data={D,C,B,A}, i_ready=1 -> o_chan 0,1,2,3,0 on consecutive cycles with o_data A,B,C,D,A.
REQ-036 SHALL cover backpressure: FULL with o_data=4'h5, i_ready=0 for 3 cycles, i_valid=4'b0010 -> o_grant=0, o_data=4'h5 held; i_ready=1 -> channel 1 granted the same cycle.
REQ-037 SHALL cover drain/idle: one word 4'hA accepted, no further valid -> o_valid falls; o_data=DEFAULT_VAL (macro off) or 4'hA (macro on).
REQ-038 SHALL cover enable gating: i_en=0, i_valid=4'b1111 -> o_grant=0, o_valid stays 0; i_en=1 -> grant channel ptr.
REQ-039 SHALL cover async reset: i_rst pulsed mid-cycle while FULL with 4'hC -> o_valid=0, o_data=DEFAULT_VAL before next edge; next grant from channel 0.
REQ-040 SHALL cover wrap: ptr=3, i_valid=4'b0001 -> channel 0 granted, ptr becomes 1.
